mem_read_responder: RTL and testbench

- Memory-side agent of the line-read interface: sits directly downstream of a read client and upstream of the line-wide SRAM.
- Accepts a single request (start address plus byte count), grants it, issues consecutive line reads to the SRAM, and streams the returned lines back as one beat per line.
- Marks the final beat with last and its valid-byte index.

---
 rtl/mem_read_responder_if.sv | 35 +++
 rtl/mem_read_responder.sv | 102 ++++++++++
 tb/tb_mem_read_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_responder_if.sv
// ============================================================================
// mem_read_responder_if : client-side line-read request/beat bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_read_responder_if #(
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH        = 19
);
  localparam int LINE_BYTES = NUM_WORDS_IN_LINE * WORD_WIDTH / 8;
  localparam int OFS        = $clog2(LINE_BYTES);

  logic                                            mem_req;
  logic [ADDR_WIDTH-1:0]                           mem_start_addr;
  logic [ADDR_WIDTH-1:0]                           mem_size_bytes;
  logic                                            mem_gnt;
  logic                                            mem_valid;
  logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0]    mem_data;
  logic                                            last;
  logic [OFS-1:0]                                  mem_last_valid;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes,
    input  mem_gnt, mem_valid, mem_data, last, mem_last_valid
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes,
    output mem_gnt, mem_valid, mem_data, last, mem_last_valid
  );
endinterface

`default_nettype wire

// File: rtl/mem_read_responder.sv
// ============================================================================
// mem_read_responder : grants one line-read request, issues SRAM line reads,
// streams one beat per line with last / last-valid-byte index.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_read_responder #(
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH        = 19
) (
  input  wire logic                                         clk,
  input  wire logic                                         rst_n,
  mem_read_responder_if.slave                               mem,
  output logic                                              sram_rd_en,
  output logic [ADDR_WIDTH-$clog2(NUM_WORDS_IN_LINE*WORD_WIDTH/8)-1:0] sram_addr,
  input  wire logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] sram_rdata,
  input  wire logic                                         sram_stall
);
  localparam int LINE_BYTES = NUM_WORDS_IN_LINE * WORD_WIDTH / 8;
  localparam int OFS        = $clog2(LINE_BYTES);
  localparam int PW         = ADDR_WIDTH - OFS;
  localparam int LW         = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic [PW-1:0]       r_line_ptr;
  logic [LW-1:0]       r_remaining;
  logic [OFS-1:0]      r_last_idx;
  logic                r_gnt;
  logic                r_valid;
  logic                r_last;

  logic [ADDR_WIDTH:0] w_size_round;
  logic [LW-1:0]       w_lines;
  logic [OFS-1:0]      w_last_idx;
  logic                w_issue;
  logic                w_final_issue;
  logic                w_unused_addr_lsbs;

  // Round up to whole lines with one extra bit so a near-max size cannot overflow.
  assign w_size_round  = {1'b0, mem.mem_size_bytes} + (ADDR_WIDTH+1)'(LINE_BYTES - 1);
  assign w_lines       = w_size_round[ADDR_WIDTH:OFS];
  assign w_last_idx    = OFS'(mem.mem_size_bytes[OFS-1:0] - OFS'(1));
  assign w_unused_addr_lsbs = ^mem.mem_start_addr[OFS-1:0];

  assign w_issue       = (r_state == S_ISSUE) && !sram_stall;
  assign w_final_issue = w_issue && (r_remaining == LW'(1));

  assign sram_rd_en         = w_issue;
  assign sram_addr          = r_line_ptr;
  assign mem.mem_gnt        = r_gnt;
  assign mem.mem_valid      = r_valid;
  assign mem.last           = r_last;
  assign mem.mem_last_valid = r_last ? r_last_idx : '0;
  assign mem.mem_data       = sram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_line_ptr  <= '0;
      r_remaining <= '0;
      r_last_idx  <= '0;
      r_gnt       <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_gnt   <= 1'b0;
      r_valid <= w_issue;
      r_last  <= w_final_issue;
      case (r_state)
        S_IDLE: begin
          if (mem.mem_req) begin
            r_gnt       <= 1'b1;
            r_line_ptr  <= mem.mem_start_addr[ADDR_WIDTH-1:OFS];
            r_remaining <= w_lines;
            r_last_idx  <= w_last_idx;
            if (w_lines != '0) begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_line_ptr  <= r_line_ptr + PW'(1);
            r_remaining <= r_remaining - LW'(1);
            if (w_final_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mem_read_responder.sv
// ============================================================================
// tb_mem_read_responder : table-driven request vectors with a beat/address
// scoreboard against a behavioural SRAM.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_read_responder;
  localparam int AW  = 19;
  localparam int OFS = 5;
  localparam int PW  = AW - OFS;
  localparam int DW  = 256;

  typedef struct {
    string          name;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  size;
    logic [15:0]    stall;
    bit             hold;
    int             abort_after;
    int             exp_lines;
    int             exp_lidx;
  } vec_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [OFS-1:0] lv;
    int             cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_rd_en;
  logic [PW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          sram_stall;

  int total = 0;
  int bad   = 0;

  beat_t         exp_q[$];
  logic [PW-1:0] addr_q[$];
  vec_t          vecs[9];

  mem_read_responder_if #(.WORD_WIDTH(8), .NUM_WORDS_IN_LINE(32), .ADDR_WIDTH(AW)) bus ();

  mem_read_responder #(.WORD_WIDTH(8), .NUM_WORDS_IN_LINE(32), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .sram_stall (sram_stall)
  );

  always #5 clk = ~clk;

  // Line L holds bytes i + 8*(L-2); line 2 is the plain byte-index pattern.
  function automatic logic [DW-1:0] line_data(input logic [PW-1:0] l);
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i + 8 * (int'(l) - 2));
    return d;
  endfunction

  always @(posedge clk) if (sram_rd_en) sram_rdata <= line_data(sram_addr);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},   bus.mem_gnt, 0);
    chk({tag, "_valid"}, bus.mem_valid, 0);
    chk({tag, "_last"},  bus.last, 0);
    chk({tag, "_lv"},    bus.mem_last_valid, 0);
    chk({tag, "_rd_en"}, sram_rd_en, 0);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_vec(input vec_t v);
    int            k, c, beats, budget, tail, last_c;
    bit            done;
    beat_t         b;
    logic [PW-1:0] l0;
    exp_q.delete();
    addr_q.delete();
    l0 = v.addr[AW-1:OFS];
    k  = 1;
    for (int j = 0; j < v.exp_lines; j++) begin
      while (k <= 16 && v.stall[k-1]) k++;
      b.data = line_data(l0 + PW'(j));
      b.last = (j == v.exp_lines - 1);
      b.lv   = b.last ? OFS'(v.exp_lidx) : '0;
      b.cyc  = k + 1;
      exp_q.push_back(b);
      addr_q.push_back(l0 + PW'(j));
      k++;
    end

    bus.mem_req        = 1'b1;
    bus.mem_start_addr = v.addr;
    bus.mem_size_bytes = v.size;
    sram_stall         = 1'b0;
    @(negedge clk);
    chk({v.name, "_gnt_early"}, bus.mem_gnt, 0);
    @(posedge clk); #1;
    if (!v.hold) bus.mem_req = 1'b0;
    sram_stall = v.stall[0];
    c = 1; beats = 0; tail = 0; last_c = -1; done = 0;
    budget = v.exp_lines + 24;
    while (!done) begin
      @(negedge clk);
      if (c == 1) chk({v.name, "_gnt"}, bus.mem_gnt, 1);
      else        chk({v.name, "_no_regrant"}, bus.mem_gnt, 0);
      if (sram_rd_en) begin
        if (addr_q.size() == 0) chk({v.name, "_extra_read"}, sram_rd_en, 0);
        else                    chk({v.name, "_sram_addr"}, sram_addr, addr_q.pop_front());
      end
      if (bus.mem_valid) begin
        if (exp_q.size() == 0) begin
          chk({v.name, "_extra_beat"}, bus.mem_valid, 0);
        end else begin
          b = exp_q.pop_front();
          chk({v.name, "_data"},  bus.mem_data, b.data);
          chk({v.name, "_last"},  bus.last, b.last);
          chk({v.name, "_lv"},    bus.mem_last_valid, b.lv);
          chk({v.name, "_cycle"}, c, b.cyc);
          beats++;
          if (b.last) last_c = c;
          if (v.abort_after > 0 && beats == v.abort_after) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_idle_outputs({v.name, "_rst"});
            rst_n = 1'b1;
            bus.mem_req = 1'b0;
            sram_stall  = 1'b0;
            @(posedge clk); #1;
            return;
          end
        end
      end else begin
        chk({v.name, "_idle_last"}, bus.last, 0);
        chk({v.name, "_idle_lv"},   bus.mem_last_valid, 0);
      end
      if (exp_q.size() == 0) tail++;
      if (tail == 4) done = 1;
      if (c >= budget) begin
        chk({v.name, "_timeout_beats_left"}, exp_q.size(), 0);
        done = 1;
      end
      @(posedge clk); #1;
      if (v.hold && c == last_c) bus.mem_req = 1'b0;
      sram_stall = (c < 16) ? v.stall[c] : 1'b0;
      c++;
    end
    bus.mem_req = 1'b0;
    sram_stall  = 1'b0;
    chk({v.name, "_beat_count"}, beats, v.exp_lines);
  endtask

  initial begin
    //          name       addr      size  stall    hold abort lines lidx
    vecs[0] = '{"single",  19'h00040,  32, 16'h0000, 0, 0, 1, 31};
    vecs[1] = '{"partial", 19'h00000,  70, 16'h0000, 0, 0, 3,  5};
    vecs[2] = '{"stall",   19'h00000, 128, 16'h0006, 0, 0, 4, 31};
    vecs[3] = '{"wrap",    19'h7FFE0,  64, 16'h0000, 0, 0, 2, 31};
    vecs[4] = '{"zero",    19'h00100,   0, 16'h0000, 0, 0, 0,  0};
    vecs[5] = '{"held",    19'h00100,  33, 16'h0000, 1, 0, 2,  0};
    vecs[6] = '{"abort",   19'h00200, 256, 16'h0000, 0, 3, 8, 31};
    vecs[7] = '{"after",   19'h01000,  40, 16'h0001, 0, 0, 2,  7};
    vecs[8] = '{"unalign", 19'h0101F,   1, 16'h0000, 0, 0, 1,  0};

    bus.mem_req        = 1'b0;
    bus.mem_start_addr = '0;
    bus.mem_size_bytes = '0;
    sram_stall         = 1'b0;
    sram_rdata         = '0;
    rst_n              = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
